// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and hazard controller for a 3-stage (IF, DE, MW) RV32I pipeline.
// Optional performance counters are built when FWD_HAZARD_PERF_EN is defined.
module fwd_hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] rs1_de,
    input  logic [REG_AW-1:0] rs2_de,
    input  logic              rs1_used_de,
    input  logic              rs2_used_de,
    input  logic [REG_AW-1:0] rd_de,
    input  logic              reg_wr_de,
    input  logic              is_load_de,
    input  logic              br_taken_de,
    input  logic              mem_ready,
    output logic              forward_a,
    output logic              forward_b,
    output logic              stall_if,
    output logic              stall_de,
    output logic              stall_mw,
    output logic              bubble_mw,
    output logic              flush_de,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        MEM_WAIT  = 2'd1,
        LU_BUBBLE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [REG_AW-1:0] rd_mw;
    logic              wr_mw;
    logic              ld_mw;
    logic              de_killed;

    logic              fwd_a_raw;
    logic              fwd_b_raw;
    logic              hit_rs1;
    logic              hit_rs2;
    logic              lu_hazard;
    logic              mem_busy;

    logic              sif;
    logic              sde;
    logic              smw;
    logic              bub;
    logic              fls;

    assign hit_rs1   = rs1_used_de & (rd_mw == rs1_de);
    assign hit_rs2   = rs2_used_de & (rd_mw == rs2_de);
    assign fwd_a_raw = wr_mw & ~ld_mw & (rd_mw != '0) & hit_rs1;
    assign fwd_b_raw = wr_mw & ~ld_mw & (rd_mw != '0) & hit_rs2;
    assign lu_hazard = ld_mw & wr_mw & (rd_mw != '0) & (hit_rs1 | hit_rs2);
    assign mem_busy  = ld_mw & ~mem_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            RUN: begin
                if (mem_busy) begin
                    state_nx = MEM_WAIT;
                end else if (lu_hazard) begin
                    state_nx = LU_BUBBLE;
                end else begin
                    state_nx = RUN;
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    state_nx = lu_hazard ? LU_BUBBLE : RUN;
                end
            end
            LU_BUBBLE: state_nx = RUN;
            default:   state_nx = RUN;
        endcase
    end

    // Priority: memory wait, then load-use, then branch flush.
    always_comb begin
        sif = 1'b0;
        sde = 1'b0;
        smw = 1'b0;
        bub = 1'b0;
        fls = 1'b0;
        case (state)
            RUN: begin
                if (mem_busy) begin
                    sif = 1'b1;
                    sde = 1'b1;
                    smw = 1'b1;
                end else if (lu_hazard) begin
                    sif = 1'b1;
                    sde = 1'b1;
                    bub = 1'b1;
                end else if (br_taken_de) begin
                    fls = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (!mem_ready) begin
                    sif = 1'b1;
                    sde = 1'b1;
                    smw = 1'b1;
                end else if (lu_hazard) begin
                    sif = 1'b1;
                    sde = 1'b1;
                    bub = 1'b1;
                end else if (br_taken_de) begin
                    fls = 1'b1;
                end
            end
            LU_BUBBLE: begin
                fls = br_taken_de;
            end
            default: begin
                fls = 1'b0;
            end
        endcase
    end

    // Outputs drop immediately while reset is asserted, even mid-stall.
    assign forward_a = rst_n & fwd_a_raw;
    assign forward_b = rst_n & fwd_b_raw;
    assign stall_if  = rst_n & sif;
    assign stall_de  = rst_n & sde;
    assign stall_mw  = rst_n & smw;
    assign bubble_mw = rst_n & bub;
    assign flush_de  = rst_n & fls;

    // The slot behind a taken branch is dead; its fields must not reach MW.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            de_killed <= 1'b0;
        end else if (!sde) begin
            de_killed <= fls;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_mw <= '0;
            wr_mw <= 1'b0;
            ld_mw <= 1'b0;
        end else if (!smw) begin
            if (bub || de_killed) begin
                rd_mw <= '0;
                wr_mw <= 1'b0;
                ld_mw <= 1'b0;
            end else begin
                rd_mw <= rd_de;
                wr_mw <= reg_wr_de;
                ld_mw <= is_load_de;
            end
        end
    end

`ifdef FWD_HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (sif && (stall_q != '1)) begin
                stall_q <= stall_q + 1'b1;
            end
            if (fls && (flush_q != '1)) begin
                flush_q <= flush_q + 1'b1;
            end
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Table-driven bench for fwd_hazard_ctrl with an expected-output queue,
// plus hand sequences for async reset mid-stall and the perf counters.
module tb_fwd_hazard_ctrl;

    localparam int REG_AW = 5;
    localparam int CNT_W  = 32;

    localparam logic [6:0] NONE = 7'b0000000;
    localparam logic [6:0] FA   = 7'b1000000;
    localparam logic [6:0] FB   = 7'b0100000;
    localparam logic [6:0] MW   = 7'b0011100;
    localparam logic [6:0] LU   = 7'b0011010;
    localparam logic [6:0] FL   = 7'b0000001;

    typedef struct {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       wr;
        logic       ld;
        logic       br;
        logic       mr;
        logic [6:0] exp;
    } vec_t;

    logic              clk;
    logic              rst_n;
    logic [REG_AW-1:0] rs1_de;
    logic [REG_AW-1:0] rs2_de;
    logic              rs1_used_de;
    logic              rs2_used_de;
    logic [REG_AW-1:0] rd_de;
    logic              reg_wr_de;
    logic              is_load_de;
    logic              br_taken_de;
    logic              mem_ready;
    logic              forward_a;
    logic              forward_b;
    logic              stall_if;
    logic              stall_de;
    logic              stall_mw;
    logic              bubble_mw;
    logic              flush_de;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    logic [6:0]        outs;
    logic [6:0]        exp_q[$];
    vec_t              vecs[23];
    int                checks;
    int                failures;

    fwd_hazard_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rs1_de      (rs1_de),
        .rs2_de      (rs2_de),
        .rs1_used_de (rs1_used_de),
        .rs2_used_de (rs2_used_de),
        .rd_de       (rd_de),
        .reg_wr_de   (reg_wr_de),
        .is_load_de  (is_load_de),
        .br_taken_de (br_taken_de),
        .mem_ready   (mem_ready),
        .forward_a   (forward_a),
        .forward_b   (forward_b),
        .stall_if    (stall_if),
        .stall_de    (stall_de),
        .stall_mw    (stall_mw),
        .bubble_mw   (bubble_mw),
        .flush_de    (flush_de),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
    );

    assign outs = {forward_a, forward_b, stall_if, stall_de, stall_mw, bubble_mw, flush_de};

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic u1, input logic u2, input logic [4:0] rd,
                                input logic wr, input logic ld, input logic br,
                                input logic mr, input logic [6:0] exp);
        vec_t v;
        v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.rd = rd;
        v.wr = wr; v.ld = ld; v.br = br; v.mr = mr; v.exp = exp;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic set_inputs(input vec_t v);
        rs1_de      = v.rs1;
        rs2_de      = v.rs2;
        rs1_used_de = v.u1;
        rs2_used_de = v.u2;
        rd_de       = v.rd;
        reg_wr_de   = v.wr;
        is_load_de  = v.ld;
        br_taken_de = v.br;
        mem_ready   = v.mr;
    endtask

    // Driver: present one DE cycle, queue its expectation, compare mid-cycle.
    task automatic apply(input vec_t v, input string name);
        logic [6:0] e;
        @(posedge clk);
        #1;
        set_inputs(v);
        exp_q.push_back(v.exp);
        @(negedge clk);
        e = exp_q.pop_front();
        check(name, {25'd0, outs}, {25'd0, e});
    endtask

    function automatic logic [31:0] perf(input logic [31:0] val);
`ifdef FWD_HAZARD_PERF_EN
        return val;
`else
        return (val == val) ? 32'd0 : 32'd0;
`endif
    endfunction

    initial begin
        checks   = 0;
        failures = 0;
        //           rs1 rs2 u1 u2 rd  wr ld br mr exp
        vecs[0]  = mk(1,  0,  1, 0, 5,  1, 0, 0, 1, NONE);    // addi x5
        vecs[1]  = mk(5,  7,  1, 1, 6,  1, 0, 0, 1, FA);      // add x6,x5,x7
        vecs[2]  = mk(7,  6,  1, 1, 8,  1, 0, 0, 1, FB);
        vecs[3]  = mk(8,  8,  1, 1, 0,  1, 0, 0, 1, FA | FB); // producer rd=x0
        vecs[4]  = mk(0,  0,  1, 1, 5,  1, 0, 0, 1, NONE);    // reads x0
        vecs[5]  = mk(5,  5,  0, 0, 5,  1, 1, 0, 1, NONE);    // unused sources; lw x5
        vecs[6]  = mk(5,  2,  1, 1, 6,  1, 0, 0, 1, LU);      // load-use
        vecs[7]  = mk(5,  2,  1, 1, 6,  1, 0, 0, 1, NONE);    // re-presented
        vecs[8]  = mk(6,  0,  1, 0, 7,  1, 1, 0, 1, FA);      // lw x7
        vecs[9]  = mk(1,  0,  1, 0, 3,  1, 0, 0, 0, MW);
        vecs[10] = mk(1,  0,  1, 0, 3,  1, 0, 1, 0, MW);      // branch ignored
        vecs[11] = mk(1,  0,  1, 0, 3,  1, 0, 0, 0, MW);
        vecs[12] = mk(1,  0,  1, 0, 3,  1, 0, 0, 1, NONE);    // released
        vecs[13] = mk(0,  0,  0, 0, 0,  0, 0, 1, 1, FL);
        vecs[14] = mk(0,  0,  0, 0, 0,  0, 0, 0, 0, NONE);    // no load: no wait
        vecs[15] = mk(0,  0,  0, 0, 10, 1, 1, 0, 1, NONE);    // lw x10
        vecs[16] = mk(0,  10, 0, 1, 11, 1, 0, 0, 0, MW);
        vecs[17] = mk(0,  10, 0, 1, 11, 1, 0, 0, 0, MW);
        vecs[18] = mk(0,  10, 0, 1, 11, 1, 0, 0, 0, MW);
        vecs[19] = mk(0,  10, 0, 1, 11, 1, 0, 1, 1, LU);      // exit into load-use
        vecs[20] = mk(0,  10, 0, 1, 11, 1, 0, 1, 1, FL);      // flush in LU_BUBBLE
        vecs[21] = mk(11, 0,  1, 0, 0,  0, 0, 0, 1, FA);
        vecs[22] = mk(11, 0,  1, 0, 0,  0, 0, 0, 1, NONE);

        rst_n = 1'b0;
        set_inputs(mk(1, 2, 1, 1, 3, 1, 1, 1, 0, NONE));
        #3;
        check("reset_outputs", {25'd0, outs}, 32'd0);
        check("reset_stall_cnt", stall_cnt, 32'd0);
        set_inputs(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, NONE));
        #9 rst_n = 1'b1;

        for (int i = 0; i < 23; i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end
        @(posedge clk);
        #1;
        check("stall_cnt_total", stall_cnt, perf(32'd8));
        check("flush_cnt_total", flush_cnt, perf(32'd2));

        // Async reset in the middle of a memory wait.
        apply(mk(0, 0, 0, 0, 5, 1, 1, 0, 1, NONE), "seq_lw");
        apply(mk(5, 0, 1, 0, 6, 1, 0, 1, 0, MW), "seq_wait0");
        @(posedge clk);
        #2;
        check("seq_wait1", {25'd0, outs}, {25'd0, MW});
        rst_n = 1'b0;
        #1;
        check("rst_mid_stall_outs", {25'd0, outs}, 32'd0);
        check("rst_mid_stall_cnt", stall_cnt, 32'd0);
        check("rst_mid_flush_cnt", flush_cnt, 32'd0);
        @(negedge clk);
        set_inputs(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, NONE));
        #2 rst_n = 1'b1;

        // Three-cycle memory wait followed by one load-use cycle.
        for (int i = 15; i < 20; i++) begin
            apply(vecs[i], $sformatf("seq2_vec%0d", i));
        end
        @(posedge clk);
        #1;
        check("stall_cnt_4", stall_cnt, perf(32'd4));
        check("flush_cnt_0", flush_cnt, 32'd0);
        check("exp_q_empty", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
